// File: rtl/dram_pkg.sv
// dram_pkg -- shared definitions for the DRAM line responder slice.
//   LINE_W    : width of one memory line in bits
//   INF_LINE  : value returned for reads outside the populated array
//   rd_state_t: read channel FSM states
//   wr_state_t: write channel FSM states
//   addr_oor  : true when a 32-bit line address lies beyond 2**addr_w lines
package dram_pkg;

    localparam int unsigned LINE_W = 1024;
    localparam logic [LINE_W-1:0] INF_LINE = '1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_WAIT = 1'b1
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/dram_line_responder_line_ram.sv
// line_ram -- 1R1W synchronous line array with a registered read port.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (read register only; array is not reset)
//   we    : write strobe; waddr/wdata committed at the rising edge
//   re    : read strobe; rdata loads mem[raddr] at the rising edge
//   rdata : registered read data, held between read strobes
// A read and write to the same line at the same edge returns the old line.
module line_ram
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dram_line_responder.sv
// dram_line_responder -- fixed-latency DRAM line model with independent
// read and write channels.
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   raddr, renable    : read request (line address, one-cycle pulse)
//   rready, rdata     : read channel idle / returned line (held until next return)
//   waddr, wdata,
//   wenable           : write request (line address, line data, one-cycle pulse)
//   wready            : write channel idle, previous write committed
//   err_oor           : sticky, an accepted address was beyond the array
//   err_proto         : sticky, an enable arrived while its channel was busy
module dram_line_responder
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned WR_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       raddr,
    input  logic              renable,
    output logic              rready,
    output logic [LINE_W-1:0] rdata,
    input  logic [31:0]       waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic              wenable,
    output logic              wready,
    output logic              err_oor,
    output logic              err_proto
);

    localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

    rd_state_t         r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_oor;
    logic              r_inf;

    wr_state_t         w_state;
    logic [3:0]        w_cnt;
    logic [ADDR_W-1:0] w_addr;
    logic [LINE_W-1:0] w_data;
    logic              w_oor;

    logic              r_accept, r_done;
    logic              w_accept, w_done;
    logic [LINE_W-1:0] ram_rdata;

    assign rready   = (r_state == R_IDLE);
    assign wready   = (w_state == W_IDLE);
    assign r_accept = renable && rready;
    assign w_accept = wenable && wready;
    assign r_done   = (r_state == R_WAIT) && (r_cnt == 4'd0);
    assign w_done   = (w_state == W_BUSY) && (w_cnt == 4'd0);

    // Out-of-range reads skip the array entirely; r_inf swaps in the
    // all-ones line on the same edge the array would have been read.
    assign rdata = r_inf ? INF_LINE : ram_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_oor   <= 1'b0;
            r_inf   <= 1'b0;
        end else if (r_accept) begin
            r_state <= R_WAIT;
            r_cnt   <= RD_INIT;
            r_addr  <= raddr[ADDR_W-1:0];
            r_oor   <= addr_oor(raddr, ADDR_W);
        end else if (r_state == R_WAIT) begin
            if (r_done) begin
                r_state <= R_IDLE;
                r_inf   <= r_oor;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            w_addr  <= '0;
            w_data  <= '0;
            w_oor   <= 1'b0;
        end else if (w_accept) begin
            w_state <= W_BUSY;
            w_cnt   <= WR_INIT;
            w_addr  <= waddr[ADDR_W-1:0];
            w_data  <= wdata;
            w_oor   <= addr_oor(waddr, ADDR_W);
        end else if (w_state == W_BUSY) begin
            if (w_done) begin
                w_state <= W_IDLE;
            end else begin
                w_cnt <= w_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_oor   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if ((r_accept && addr_oor(raddr, ADDR_W)) ||
                (w_accept && addr_oor(waddr, ADDR_W))) begin
                err_oor <= 1'b1;
            end
            if ((renable && !rready) || (wenable && !wready)) begin
                err_proto <= 1'b1;
            end
        end
    end

    line_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_done && !w_oor),
        .waddr (w_addr),
        .wdata (w_data),
        .re    (r_done && !r_oor),
        .raddr (r_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dram_line_responder.sv
module tb_dram_line_responder;
    import dram_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RD_LAT = 4;
    localparam int unsigned WR_LAT = 2;
    localparam int unsigned DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       raddr = '0;
    logic              renable = 1'b0;
    logic              rready;
    logic [LINE_W-1:0] rdata;
    logic [31:0]       waddr = '0;
    logic [LINE_W-1:0] wdata = '0;
    logic              wenable = 1'b0;
    logic              wready;
    logic              err_oor;
    logic              err_proto;

    always #5 clk = ~clk;

    dram_line_responder #(
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT),
        .WR_LAT(WR_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raddr     (raddr),
        .renable   (renable),
        .rready    (rready),
        .rdata     (rdata),
        .waddr     (waddr),
        .wdata     (wdata),
        .wenable   (wenable),
        .wready    (wready),
        .err_oor   (err_oor),
        .err_proto (err_proto)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got low128 %h expected low128 %h at %0t",
                     name, act[127:0], exp[127:0], $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] fill(input logic [7:0] b);
        return {128{b}};
    endfunction

    // Behavioural model: each accepted request is a record with a due cycle.
    // At the due edge a read takes the memory line as it stood before any
    // write landing on that same edge.
    longint unsigned   cyc = 0;
    bit                m_rbusy, m_wbusy;
    longint unsigned   m_rdue, m_wdue;
    logic [31:0]       m_raddr, m_waddr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    bit                m_rknown;
    bit                m_oor, m_proto;
    logic [LINE_W-1:0] mem [DEPTH];
    bit                known [DEPTH];
    bit                run_checks = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_rbusy  = 1'b0;
                m_wbusy  = 1'b0;
                m_rdata  = '0;
                m_rknown = 1'b1;
                m_oor    = 1'b0;
                m_proto  = 1'b0;
            end else begin
                bit pre_r, pre_w;
                cyc++;
                pre_r = m_rbusy;
                pre_w = m_wbusy;
                if (m_rbusy && cyc == m_rdue) begin
                    if (m_raddr >= DEPTH) begin
                        m_rdata  = '1;
                        m_rknown = 1'b1;
                    end else begin
                        m_rdata  = mem[m_raddr];
                        m_rknown = known[m_raddr];
                    end
                    m_rbusy = 1'b0;
                end
                if (m_wbusy && cyc == m_wdue) begin
                    if (m_waddr < DEPTH) begin
                        mem[m_waddr]   = m_wdata;
                        known[m_waddr] = 1'b1;
                    end
                    m_wbusy = 1'b0;
                end
                if (renable) begin
                    if (!pre_r) begin
                        m_rbusy = 1'b1;
                        m_rdue  = cyc + RD_LAT;
                        m_raddr = raddr;
                        if (raddr >= DEPTH) m_oor = 1'b1;
                    end else begin
                        m_proto = 1'b1;
                    end
                end
                if (wenable) begin
                    if (!pre_w) begin
                        m_wbusy = 1'b1;
                        m_wdue  = cyc + WR_LAT;
                        m_waddr = waddr;
                        m_wdata = wdata;
                        if (waddr >= DEPTH) m_oor = 1'b1;
                    end else begin
                        m_proto = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (run_checks && reset) begin
                chk_bit("rready", rready, !m_rbusy);
                chk_bit("wready", wready, !m_wbusy);
                chk_bit("err_oor", err_oor, m_oor);
                chk_bit("err_proto", err_proto, m_proto);
                if (m_rknown) chk_line("rdata", rdata, m_rdata);
            end
        end
    end

    task automatic drive_rd(input logic [31:0] a);
        renable = 1'b1;
        raddr   = a;
        @(negedge clk);
        renable = 1'b0;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [LINE_W-1:0] d);
        wenable = 1'b1;
        waddr   = a;
        wdata   = d;
        @(negedge clk);
        wenable = 1'b0;
    endtask

    task automatic wait_r(output int n);
        n = 0;
        while (!rready && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!rready) begin
            checks++;
            errors++;
            $display("FAIL rready_timeout: got rready=0 expected 1 within 64 cycles");
        end
    endtask

    task automatic wait_w(output int n);
        n = 0;
        while (!wready && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!wready) begin
            checks++;
            errors++;
            $display("FAIL wready_timeout: got wready=0 expected 1 within 64 cycles");
        end
    endtask

    task automatic make_line(output logic [LINE_W-1:0] l);
        for (int i = 0; i < 32; i++) l[i*32 +: 32] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ops;
        logic [LINE_W-1:0] d;

        repeat (3) @(negedge clk);
        #1;
        chk_bit("reset_rready", rready, 1'b1);
        chk_bit("reset_wready", wready, 1'b1);
        chk_line("reset_rdata", rdata, '0);
        chk_bit("reset_err_oor", err_oor, 1'b0);
        chk_bit("reset_err_proto", err_proto, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        run_checks = 1'b1;

        // Write then read of one line with fixed latencies.
        drive_wr(32'd3, fill(8'hA5));
        wait_w(n);
        chk_int("wr_busy_cycles", n, 2);
        drive_rd(32'd3);
        wait_r(n);
        chk_int("rd_busy_cycles", n, 4);
        chk_line("rd_a5", rdata, fill(8'hA5));

        // Write commit on the same edge as read return yields the old line.
        drive_wr(32'd5, fill(8'h11));
        wait_w(n);
        drive_rd(32'd5);
        @(negedge clk);
        drive_wr(32'd5, fill(8'h22));
        wait_r(n);
        chk_int("rd_overlap_remaining", n, 2);
        chk_line("rd_old_line", rdata, fill(8'h11));
        wait_w(n);
        drive_rd(32'd5);
        wait_r(n);
        chk_line("rd_new_line", rdata, fill(8'h22));

        // Out-of-range read and write.
        drive_wr(32'd0, fill(8'h33));
        wait_w(n);
        drive_rd(32'd300);
        wait_r(n);
        chk_int("rd_oor_cycles", n, 4);
        chk_line("rd_oor_inf", rdata, '1);
        chk_bit("err_oor_after_rd", err_oor, 1'b1);
        drive_wr(32'd256, fill(8'h77));
        wait_w(n);
        chk_int("wr_oor_cycles", n, 2);
        drive_rd(32'd0);
        wait_r(n);
        chk_line("rd_line0_untouched", rdata, fill(8'h33));
        chk_bit("err_oor_sticky", err_oor, 1'b1);

        // Enable while busy is ignored and flagged.
        chk_bit("err_proto_before", err_proto, 1'b0);
        drive_rd(32'd3);
        drive_rd(32'd5);
        chk_bit("err_proto_set", err_proto, 1'b1);
        wait_r(n);
        chk_int("rd_after_proto_remaining", n, 3);
        chk_line("rd_after_proto", rdata, fill(8'hA5));

        // Reset in the middle of a write discards it.
        drive_wr(32'd3, fill(8'hEE));
        #2;
        reset = 1'b0;
        #1;
        chk_bit("midreset_wready", wready, 1'b1);
        chk_bit("midreset_rready", rready, 1'b1);
        chk_line("midreset_rdata", rdata, '0);
        chk_bit("midreset_err_oor", err_oor, 1'b0);
        chk_bit("midreset_err_proto", err_proto, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive_rd(32'd3);
        wait_r(n);
        chk_line("rd_after_reset", rdata, fill(8'hA5));

        // Populate every line, then concurrent random traffic.
        for (int i = 0; i < int'(DEPTH); i++) begin
            make_line(d);
            drive_wr(32'(i), d);
            wait_w(n);
        end
        ops = 0;
        for (int c = 0; c < 2000 && ops < 100; c++) begin
            if (rready) begin
                renable = 1'b1;
                raddr   = $urandom_range(0, 255);
                ops++;
            end
            if (wready) begin
                make_line(d);
                wenable = 1'b1;
                waddr   = $urandom_range(0, 255);
                wdata   = d;
            end
            @(negedge clk);
            renable = 1'b0;
            wenable = 1'b0;
        end
        wait_r(n);
        wait_w(n);
        chk_int("random_reads_issued", ops, 100);
        chk_bit("random_err_oor", err_oor, 1'b0);
        chk_bit("random_err_proto", err_proto, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
